spi_shift_engine: RTL and testbench

//  Byte-level SPI master PHY under the SPI device controller: accepts one tx word plus
//  a target select, drives SCLK/MOSI/SS_n in SPI mode 0 (CPOL=0, CPHA=0, MSB first),
//  and returns the word sampled on MISO.
//  The controller sequences commands; this block owns every pin-level timing detail.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_shift_engine.sv | 174 +++++++++++++++++
 tb/tb_spi_shift_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and chip-select indices for the SPI shift engine.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    HELD,
    GAP
  } spi_state_e;

  localparam int unsigned SS_FLASH = 0;
  localparam int unsigned SS_SEG   = 1;
  localparam int unsigned SS_SR    = 2;
  localparam int unsigned SS_MPU   = 3;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: counts 0..CLK_DIV-1 while enabled, tick marks the wrap cycle.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-level SPI mode-0 master PHY: owns SCLK/MOSI/SS_n timing for one word per start.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_SS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ready,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic [$clog2(NUM_SS)-1:0] ss_sel,
  input  logic                      hold_ss,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      busy,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  input  logic                      spi_miso,
  output logic [NUM_SS-1:0]         spi_ss_n
);

  localparam int unsigned SW     = $clog2(NUM_SS);
  localparam int unsigned HALF_N = 2 * DATA_W;
  localparam int unsigned BW     = $clog2(HALF_N) + 1;

  spi_state_e        state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rxd_q, rxd_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              hold_q, hold_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d, dec_new, dec_held;
  logic              sclk_q, sclk_d, mosi_q, mosi_d;
  logic              ready_q, ready_d, busy_q, busy_d, rxv_q, rxv_d;
  logic              accept, tick, div_en;

  assign accept = start && ready_q;
  assign div_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == GAP);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (accept),
    .tick (tick)
  );

  // Active-low select patterns for the incoming and the currently held target.
  always_comb begin
    dec_new  = '1;
    dec_held = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SW'(i)) dec_new[i] = 1'b0;
      if (sel_q == SW'(i)) dec_held[i] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rxv_d   = 1'b0;

    case (state_q)
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          bit_d  = bit_q + BW'(1);
          if (!sclk_q) begin
            rx_d = {rx_q[DATA_W-2:0], spi_miso};
          end else begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[DATA_W-2];
          end
          if (bit_q == BW'(HALF_N - 1)) state_d = DONE;
        end
      end
      DONE: begin
        rxv_d = 1'b1;
        rxd_d = rx_q;
        if (hold_q) begin
          state_d = HELD;
        end else begin
          state_d = IDLE;
          ss_n_d  = '1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = SETUP;
          ss_n_d  = dec_held;
        end
      end
      IDLE, HELD: ;
      default: state_d = IDLE;
    endcase

    // A held select only needs the gap when the target changes.
    if (accept) begin
      tx_d   = tx_data;
      sel_d  = ss_sel;
      hold_d = hold_ss;
      mosi_d = tx_data[DATA_W-1];
      sclk_d = 1'b0;
      bit_d  = '0;
      if ((state_q == HELD || (state_q == DONE && hold_q)) && ss_sel != sel_q) begin
        state_d = GAP;
        ss_n_d  = '1;
      end else begin
        state_d = SETUP;
        ss_n_d  = dec_new;
      end
    end

    ready_d = (state_d == IDLE) || (state_d == HELD) || (state_d == DONE);
    busy_d  = !((state_d == IDLE) || (state_d == HELD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      sel_q   <= '0;
      hold_q  <= 1'b0;
      ss_n_q  <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rxv_q   <= rxv_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign rx_valid = rxv_q;
  assign rx_data  = rxd_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine at CLK_DIV=2, DATA_W=8.
module tb_spi_shift_engine;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold_ss = 1'b0;
  logic [7:0] tx_data = '0;
  logic [1:0] ss_sel = '0;
  logic       loop_en = 1'b1;
  logic       miso_drv = 1'b0;
  logic       ready, rx_valid, busy, spi_sclk, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  logic [3:0] spi_ss_n;

  int vectors = 0;
  int miscompares = 0;

  assign spi_miso = loop_en ? spi_mosi : miso_drv;

  always #5 clk = ~clk;

  spi_shift_engine #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ready    (ready),
    .tx_data  (tx_data),
    .ss_sel   (ss_sel),
    .hold_ss  (hold_ss),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one sample point after the accepting edge.
  task automatic issue(input logic [7:0] d, input logic [1:0] s, input logic h);
    tx_data = d; ss_sel = s; hold_ss = h; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_rxv(input int bound, output int lat, output logic [7:0] data);
    lat = -1; data = 'x;
    for (int n = 1; n <= bound; n++) begin
      step();
      if (rx_valid) begin lat = n; data = rx_data; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rxv: got %b want 0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rxd: got %h want 00", rx_data); end
    vectors++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_pins: sclk %b mosi %b want 0 0", spi_sclk, spi_mosi); end
    vectors++; if (spi_ss_n !== 4'hF) begin miscompares++; $display("FAIL reset_ss: got %b want 1111", spi_ss_n); end
    rst = 1'b0; step();
  endtask

  task automatic test_loopback();
    int lat, bad_ss;
    logic [7:0] got;
    lat = -1; bad_ss = 0; got = 'x; loop_en = 1'b1;
    issue(8'hA5, 2'(SS_FLASH), 1'b0);
    vectors++; if (busy !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL lb_busy: busy %b ready %b want 1 0", busy, ready); end
    for (int n = 0; n <= 100; n++) begin
      if (n > 0) step();
      if (rx_valid) begin lat = n; got = rx_data; break; end
      if (spi_ss_n !== 4'b1110) bad_ss++;
    end
    vectors++; if (lat != 35) begin miscompares++; $display("FAIL lb_latency: got %0d want 35", lat); end
    vectors++; if (got !== 8'hA5) begin miscompares++; $display("FAIL lb_rxdata: got %h want a5", got); end
    vectors++; if (bad_ss != 0) begin miscompares++; $display("FAIL lb_ss_during: %0d bad cycles want 0", bad_ss); end
    vectors++; if (spi_ss_n !== 4'hF) begin miscompares++; $display("FAIL lb_ss_after: got %b want 1111", spi_ss_n); end
    step();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL lb_pulse_width: got %b want 0", rx_valid); end
  endtask

  task automatic test_miso_model();
    int lat, rises, viol, k;
    logic prev_s, prev_m;
    logic [7:0] pat, seen, got;
    pat = 8'hC3; k = 0; lat = -1; rises = 0; viol = 0; seen = '0; got = 'x;
    loop_en = 1'b0; miso_drv = pat[7];
    issue(8'h3C, 2'(SS_SEG), 1'b0);
    prev_s = spi_sclk; prev_m = spi_mosi;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (rx_valid) begin lat = n; got = rx_data; break; end
      if (!prev_s && spi_sclk) begin rises++; seen = {seen[6:0], spi_mosi}; end
      if (spi_mosi !== prev_m && !(prev_s && !spi_sclk)) viol++;
      if (prev_s && !spi_sclk && k < 7) begin k++; miso_drv = pat[3'(7 - k)]; end
      prev_s = spi_sclk; prev_m = spi_mosi;
    end
    vectors++; if (got !== 8'hC3) begin miscompares++; $display("FAIL miso_rxdata: got %h want c3", got); end
    vectors++; if (rises != 8) begin miscompares++; $display("FAIL sclk_rises: got %0d want 8", rises); end
    vectors++; if (seen !== 8'h3C) begin miscompares++; $display("FAIL mosi_bits: got %h want 3c", seen); end
    vectors++; if (viol != 0) begin miscompares++; $display("FAIL mosi_timing: %0d bad changes want 0", viol); end
    vectors++; if (lat != 35) begin miscompares++; $display("FAIL miso_latency: got %0d want 35", lat); end
    loop_en = 1'b1;
  endtask

  task automatic test_hold_burst();
    int lat1, lat2, bad_ss, extra;
    logic [7:0] r1, r2;
    lat1 = -1; lat2 = -1; bad_ss = 0; extra = 0; r1 = 'x; r2 = 'x;
    issue(8'h03, 2'(SS_FLASH), 1'b1);
    for (int n = 0; n <= 100; n++) begin
      if (n > 0) step();
      if (spi_ss_n[0] !== 1'b0) bad_ss++;
      if (rx_valid) begin lat1 = n; r1 = rx_data; break; end
    end
    issue(8'h00, 2'(SS_FLASH), 1'b0);
    for (int n = 0; n <= 100; n++) begin
      if (n > 0) step();
      if (rx_valid) begin lat2 = n; r2 = rx_data; break; end
      if (spi_ss_n[0] !== 1'b0) bad_ss++;
    end
    vectors++; if (lat1 != 35 || lat2 != 35) begin miscompares++; $display("FAIL hold_latency: got %0d %0d want 35 35", lat1, lat2); end
    vectors++; if (r1 !== 8'h03 || r2 !== 8'h00) begin miscompares++; $display("FAIL hold_rxdata: got %h %h want 03 00", r1, r2); end
    vectors++; if (bad_ss != 0) begin miscompares++; $display("FAIL hold_ss_low: %0d bad cycles want 0", bad_ss); end
    vectors++; if (spi_ss_n !== 4'hF) begin miscompares++; $display("FAIL hold_ss_release: got %b want 1111", spi_ss_n); end
    for (int n = 0; n < 5; n++) begin step(); if (rx_valid) extra++; end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL hold_extra_pulse: got %0d want 0", extra); end
  endtask

  task automatic test_gap();
    int lat, rest;
    logic [7:0] got;
    logic [3:0] s0, s1, s2;
    issue(8'h5A, 2'(SS_FLASH), 1'b1);
    wait_rxv(100, lat, got);
    vectors++; if (lat != 35 || got !== 8'h5A) begin miscompares++; $display("FAIL gap_first: lat %0d data %h want 35 5a", lat, got); end
    issue(8'h96, 2'(SS_MPU), 1'b0);
    s0 = spi_ss_n; step(); s1 = spi_ss_n; step(); s2 = spi_ss_n;
    wait_rxv(100, rest, got);
    lat = (rest < 0) ? -1 : rest + 2;
    vectors++; if (s0 !== 4'hF || s1 !== 4'hF) begin miscompares++; $display("FAIL gap_ss_high: got %b %b want 1111 1111", s0, s1); end
    vectors++; if (s2 !== 4'b0111) begin miscompares++; $display("FAIL gap_ss_new: got %b want 0111", s2); end
    vectors++; if (lat != 37) begin miscompares++; $display("FAIL gap_latency: got %0d want 37", lat); end
    vectors++; if (got !== 8'h96) begin miscompares++; $display("FAIL gap_rxdata: got %h want 96", got); end
  endtask

  task automatic test_reset_mid();
    int rises, pulses;
    logic prev_s;
    rises = 0; pulses = 0;
    issue(8'hFF, 2'(SS_SEG), 1'b0);
    prev_s = spi_sclk;
    for (int n = 1; n <= 100 && rises < 5; n++) begin
      step();
      if (!prev_s && spi_sclk) rises++;
      prev_s = spi_sclk;
    end
    rst = 1'b1; step();
    vectors++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin miscompares++; $display("FAIL rstmid_pins: sclk %b mosi %b want 0 0", spi_sclk, spi_mosi); end
    vectors++; if (spi_ss_n !== 4'hF) begin miscompares++; $display("FAIL rstmid_ss: got %b want 1111", spi_ss_n); end
    vectors++; if (ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: ready %b busy %b want 1 0", ready, busy); end
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin step(); if (rx_valid) pulses++; end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rstmid_rxv: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_ignore_start();
    int lat, pulses;
    logic [7:0] got;
    lat = -1; pulses = 0; got = 'x;
    issue(8'h81, 2'(SS_SR), 1'b0);
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 11) start = 1'b0;
      if (rx_valid) begin pulses++; if (lat < 0) begin lat = n; got = rx_data; end end
      if (n == 10) begin
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL ign_ready: got %b want 0", ready); end
        tx_data = 8'h00; ss_sel = 2'(SS_FLASH); start = 1'b1;
      end
    end
    vectors++; if (lat != 35 || got !== 8'h81) begin miscompares++; $display("FAIL ign_result: lat %0d data %h want 35 81", lat, got); end
    vectors++; if (pulses != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL ign_requeue: pulses %0d busy %b want 1 0", pulses, busy); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [7:0] r1, r2;
    logic rdy34, busy35;
    logic [3:0] ss35;
    lat1 = -1; lat2 = -1; r1 = 'x; r2 = 'x; rdy34 = 1'bx; busy35 = 1'bx; ss35 = 'x;
    issue(8'h12, 2'(SS_SEG), 1'b0);
    tx_data = 8'h34; start = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      step();
      if (n == 34) rdy34 = ready;
      if (rx_valid && lat1 < 0) begin
        lat1 = n; r1 = rx_data; busy35 = busy; ss35 = spi_ss_n; start = 1'b0;
      end else if (rx_valid) begin
        lat2 = n - lat1; r2 = rx_data; break;
      end
    end
    start = 1'b0;
    vectors++; if (rdy34 !== 1'b1) begin miscompares++; $display("FAIL b2b_done_ready: got %b want 1", rdy34); end
    vectors++; if (lat1 != 35 || r1 !== 8'h12) begin miscompares++; $display("FAIL b2b_first: lat %0d data %h want 35 12", lat1, r1); end
    vectors++; if (busy35 !== 1'b1 || ss35 !== 4'b1101) begin miscompares++; $display("FAIL b2b_no_idle: busy %b ss %b want 1 1101", busy35, ss35); end
    vectors++; if (lat2 != 35 || r2 !== 8'h34) begin miscompares++; $display("FAIL b2b_second: lat %0d data %h want 35 34", lat2, r2); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_model();
    test_hold_burst();
    test_gap();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
